// File: rtl/ua_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and the parity helper.
// Intended for reuse by the matching receiver.
package ua_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_PAR   = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_START = ST_START,
    S_DATA  = ST_DATA,
    S_PAR   = ST_PAR,
    S_STOP  = ST_STOP
  } tx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Zero-extended upper bits do not disturb the reduction XOR.
  function automatic logic frame_parity(input logic [8:0] data, input int mode);
    logic p;
    p = ^data;
    if (mode == PAR_ODD) begin
      return ~p;
    end else begin
      return p;
    end
  endfunction

endpackage

// File: rtl/ua_tx_fifo.sv
// Show-ahead synchronous FIFO feeding the UART transmitter.
// Push is refused when full and pop when empty, so the count never wraps.
module ua_tx_fifo
  import ua_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == CW'(0));
  assign count     = count_r;
  assign rdata     = mem_r[rd_ptr_r];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Pointer and occupancy tracking; power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= PW'(0);
      rd_ptr_r <= PW'(0);
      count_r  <= CW'(0);
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

endmodule

// File: rtl/ua_tx_param.sv
// Parametrised UART transmitter: FIFO-buffered words serialised LSB-first on baud ticks,
// with optional even/odd parity and one or two stop bits.
module ua_tx_param
  import ua_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            enable,
  input  logic                            din_valid,
  input  logic [DATA_W-1:0]               din_byte,
  output logic                            din_ready,
  output logic                            ser_out,
  output logic                            tx_busy,
  output logic                            uart_ready,
  output logic                            frame_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

  localparam int BW = $clog2(DATA_W);

  if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
    $fatal(1, "ua_tx_param: DATA_W must be within 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $fatal(1, "ua_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $fatal(1, "ua_tx_param: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "ua_tx_param: FIFO_DEPTH must be a power of two >= 2");
  end

  tx_state_e         state_r;
  tx_state_e         state_n;
  logic [DATA_W-1:0] sh_r;
  logic [DATA_W-1:0] sh_n;
  logic              par_r;
  logic              par_n;
  logic [BW-1:0]     bit_cnt_r;
  logic [BW-1:0]     bit_cnt_n;
  logic              stop_cnt_r;
  logic              stop_cnt_n;
  logic              ser_r;
  logic              ser_n;
  logic              pop_s;
  logic              done_s;
  logic              full_s;
  logic              empty_s;
  logic [DATA_W-1:0] rdata_s;

  ua_tx_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (din_valid),
    .pop   (pop_s),
    .wdata (din_byte),
    .rdata (rdata_s),
    .full  (full_s),
    .empty (empty_s),
    .count (fifo_count)
  );

  assign din_ready  = !full_s;
  assign ser_out    = ser_r;
  assign tx_busy    = (state_r != S_IDLE);
  assign uart_ready = (state_r == S_IDLE) && empty_s;
  assign frame_done = done_s;

  // State and datapath registers; the line is forced idle-high by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= S_IDLE;
      sh_r       <= DATA_W'(0);
      par_r      <= 1'b0;
      bit_cnt_r  <= BW'(0);
      stop_cnt_r <= 1'b0;
      ser_r      <= 1'b1;
    end else begin
      state_r    <= state_n;
      sh_r       <= sh_n;
      par_r      <= par_n;
      bit_cnt_r  <= bit_cnt_n;
      stop_cnt_r <= stop_cnt_n;
      ser_r      <= ser_n;
    end
  end

  // Next-state logic; ser_n always carries the bit of the state being entered.
  always_comb begin
    state_n    = state_r;
    sh_n       = sh_r;
    par_n      = par_r;
    bit_cnt_n  = bit_cnt_r;
    stop_cnt_n = stop_cnt_r;
    ser_n      = ser_r;
    pop_s      = 1'b0;
    done_s     = 1'b0;
    if (enable) begin
      case (state_r)
        S_IDLE: begin
          if (!empty_s) begin
            pop_s   = 1'b1;
            sh_n    = rdata_s;
            par_n   = frame_parity(9'(rdata_s), PARITY);
            state_n = S_START;
            ser_n   = 1'b0;
          end else begin
            ser_n = 1'b1;
          end
        end
        S_START: begin
          state_n   = S_DATA;
          ser_n     = sh_r[0];
          bit_cnt_n = BW'(0);
        end
        S_DATA: begin
          if (bit_cnt_r != BW'(DATA_W - 1)) begin
            sh_n      = sh_r >> 1;
            ser_n     = sh_r[1];
            bit_cnt_n = bit_cnt_r + BW'(1);
          end else if (PARITY != PAR_NONE) begin
            state_n = S_PAR;
            ser_n   = par_r;
          end else begin
            state_n    = S_STOP;
            ser_n      = 1'b1;
            stop_cnt_n = 1'b0;
          end
        end
        S_PAR: begin
          state_n    = S_STOP;
          ser_n      = 1'b1;
          stop_cnt_n = 1'b0;
        end
        S_STOP: begin
          if (stop_cnt_r != 1'(STOP_BITS - 1)) begin
            stop_cnt_n = 1'b1;
            ser_n      = 1'b1;
          end else begin
            done_s = 1'b1;
            // A queued word starts immediately so frames run back-to-back.
            if (!empty_s) begin
              pop_s   = 1'b1;
              sh_n    = rdata_s;
              par_n   = frame_parity(9'(rdata_s), PARITY);
              state_n = S_START;
              ser_n   = 1'b0;
            end else begin
              state_n = S_IDLE;
              ser_n   = 1'b1;
            end
          end
        end
        default: begin
          state_n = S_IDLE;
          ser_n   = 1'b1;
        end
      endcase
    end else begin
      state_n = state_r;
    end
  end

endmodule

// File: tb/tb_ua_tx_param.sv
// Self-checking bench for ua_tx_param: three configurations checked tick-by-tick
// against a frame-list model built from the line protocol.
module tb_ua_tx_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [2:0]      en;
  logic [2:0]      dv;
  logic [2:0]      ser;
  logic [2:0]      dready;
  logic [2:0]      busy;
  logic [2:0]      uready;
  logic [2:0]      fdone;
  logic [2:0][2:0] cnt;
  logic [7:0]      din_a;
  logic [7:0]      din_b;
  logic [6:0]      din_c;

  ua_tx_param #(.DATA_W(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .enable(en[0]), .din_valid(dv[0]), .din_byte(din_a),
    .din_ready(dready[0]), .ser_out(ser[0]), .tx_busy(busy[0]), .uart_ready(uready[0]),
    .frame_done(fdone[0]), .fifo_count(cnt[0]));

  ua_tx_param #(.DATA_W(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .enable(en[1]), .din_valid(dv[1]), .din_byte(din_b),
    .din_ready(dready[1]), .ser_out(ser[1]), .tx_busy(busy[1]), .uart_ready(uready[1]),
    .frame_done(fdone[1]), .fifo_count(cnt[1]));

  ua_tx_param #(.DATA_W(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_c (
    .clk(clk), .rst(rst), .enable(en[2]), .din_valid(dv[2]), .din_byte(din_c),
    .din_ready(dready[2]), .ser_out(ser[2]), .tx_busy(busy[2]), .uart_ready(uready[2]),
    .frame_done(fdone[2]), .fifo_count(cnt[2]));

  localparam int DEPTH = 4;
  int dw [3] = '{8, 8, 7};
  int pm [3] = '{0, 1, 2};
  int sb [3] = '{1, 1, 2};

  int          checks = 0;
  int          errors = 0;
  int          q [$];
  logic        cur_bit;
  logic        prev_last;
  logic        in_frame;
  int          mcount;
  int          done_seen;
  logic [15:0] trace;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    cur_bit   = 1'b1;
    prev_last = 1'b0;
    in_frame  = 1'b0;
    mcount    = 0;
  endfunction

  // Entry encoding: bit0 line value, bit1 start bit, bit2 final stop bit.
  function automatic void model_push(input int idx, input logic [8:0] w);
    int ones = 0;
    q.push_back(2);
    for (int i = 0; i < dw[idx]; i++) begin
      q.push_back(int'(w[i]));
      ones += int'(w[i]);
    end
    if (pm[idx] == 1) q.push_back(ones % 2);
    if (pm[idx] == 2) q.push_back(1 - (ones % 2));
    for (int s = 0; s < sb[idx]; s++) q.push_back((s == sb[idx] - 1) ? 5 : 1);
    mcount++;
  endfunction

  function automatic void model_tick();
    int e;
    if (q.size() > 0) begin
      e = q.pop_front();
      cur_bit   = e[0];
      prev_last = e[2];
      in_frame  = 1'b1;
      if (e[1]) mcount--;
    end else begin
      cur_bit   = 1'b1;
      prev_last = 1'b0;
      in_frame  = 1'b0;
    end
  endfunction

  task automatic push(input int idx, input logic [8:0] w);
    logic acc;
    case (idx)
      0:       din_a = w[7:0];
      1:       din_b = w[7:0];
      default: din_c = w[6:0];
    endcase
    dv[idx] = 1'b1;
    #1;
    acc = (mcount < DEPTH);
    chk("din_ready", dready[idx], acc);
    @(posedge clk);
    #1;
    dv[idx] = 1'b0;
    if (acc) model_push(idx, w);
    chk("fifo_count_push", cnt[idx], mcount);
    chk("uart_ready_push", uready[idx], (!in_frame && mcount == 0));
    @(negedge clk);
  endtask

  task automatic tick(input int idx, input int period);
    for (int c = 0; c < period; c++) begin
      en[idx] = (c == period - 1);
      #1;
      chk("frame_done", fdone[idx], en[idx] ? prev_last : 1'b0);
      if (fdone[idx] === 1'b1) done_seen++;
      @(posedge clk);
      #1;
      en[idx] = 1'b0;
      if (c == period - 1) begin
        model_tick();
        chk("tx_busy", busy[idx], in_frame);
        chk("uart_ready", uready[idx], (!in_frame && mcount == 0));
        chk("fifo_count", cnt[idx], mcount);
        trace = {trace[14:0], ser[idx]};
      end
      chk("ser_out", ser[idx], cur_bit);
      @(negedge clk);
    end
  endtask

  task automatic run(input int idx, input int period, input int n);
    for (int t = 0; t < n; t++) tick(idx, period);
  endtask

  initial begin
    int n;
    int per;
    int flen;
    rst = 1'b1; en = 3'b000; dv = 3'b000;
    din_a = 8'h00; din_b = 8'h00; din_c = 7'h00;
    trace = 16'h0000; done_seen = 0;
    model_reset();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_ser_out", ser[i], 1'b1);
      chk("rst_din_ready", dready[i], 1'b1);
      chk("rst_uart_ready", uready[i], 1'b1);
      chk("rst_tx_busy", busy[i], 1'b0);
      chk("rst_frame_done", fdone[i], 1'b0);
      chk("rst_fifo_count", cnt[i], 3'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // 8N1 0x55, enable every cycle
    done_seen = 0;
    push(0, 9'h055);
    run(0, 1, 11);
    chk("trace_8n1_55", trace[10:0], 11'b0_10101010_1_1);
    chk("done_8n1_55", done_seen, 1);

    // even parity, 0x07
    done_seen = 0;
    push(1, 9'h007);
    run(1, 1, 12);
    chk("trace_even_07", trace[11:0], 12'b0_11100000_1_1_1);
    chk("done_even_07", done_seen, 1);

    // 7 data bits, odd parity, two stop bits
    push(2, 9'h007);
    run(2, 1, 12);
    chk("trace_7o2_07", trace[11:0], 12'b0_1110000_0_11_1);
    push(2, 9'h041);
    run(2, 1, 12);
    chk("trace_7o2_41", trace[11:0], 12'b0_1000001_1_11_1);

    // FIFO fill with enable held low, fifth word refused, then contiguous drain
    done_seen = 0;
    for (int i = 0; i < 5; i++) push(0, 9'($urandom));
    chk("full_count", cnt[0], 3'd4);
    chk("full_ready", dready[0], 1'b0);
    run(0, 1, 41);
    chk("done_four_frames", done_seen, 4);

    // slow baud: one enable every 16 clocks
    done_seen = 0;
    push(0, 9'h0A3);
    run(0, 16, 11);
    chk("trace_slow_a3", trace[10:0], 11'b0_11000101_1_1);
    chk("done_slow_a3", done_seen, 1);

    // randomized bursts on every configuration
    for (int idx = 0; idx < 3; idx++) begin
      for (int r = 0; r < 3; r++) begin
        n    = int'($urandom_range(1, 4));
        per  = int'($urandom_range(1, 3));
        flen = 1 + dw[idx] + ((pm[idx] != 0) ? 1 : 0) + sb[idx];
        for (int k = 0; k < n; k++) push(idx, 9'($urandom));
        run(idx, per, n * flen + 2);
      end
    end

    // reset during DATA bit 3 with a second word queued
    push(0, 9'h0F0);
    push(0, 9'h0A5);
    run(0, 1, 5);
    chk("pre_rst_bit3", ser[0], 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_ser_out", ser[0], 1'b1);
    chk("mid_rst_count", cnt[0], 3'd0);
    chk("mid_rst_busy", busy[0], 1'b0);
    chk("mid_rst_done", fdone[0], 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    done_seen = 0;
    run(0, 1, 12);
    chk("post_rst_no_done", done_seen, 0);
    chk("post_rst_uart_ready", uready[0], 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ua_tx_param.md
# ua_tx_param

Parametrised UART transmitter with a small input FIFO, configurable data width, parity and stop bits. It replaces the fixed 8N1 shift-register transmitter in the UART path. Bytes are queued over a valid/ready handshake and serialised LSB-first at the rate set by an external baud-tick `enable`. Frames are sent back-to-back while the FIFO holds data.

## Interface
Parameters:
- `DATA_W`, default 8: data bits per frame; legal range 5..9.
- `PARITY`, default 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, default 1: legal values 1 or 2.
- `FIFO_DEPTH`, default 4: entries; power of two, ≥ 2.

Ports:
- `clk`  in  1: system clock; all logic on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `enable`  in  1: baud tick; the FSM advances only on cycles where it is 1.
- `din_valid`  in  1: a data word is offered.
- `din_byte`  in  DATA_W: data word.
- `din_ready`  out  1: FIFO not full; a push occurs when `din_valid && din_ready`.
- `ser_out`  out  1: serial line, registered, idle high.
- `tx_busy`  out  1: FSM not in IDLE.
- `uart_ready`  out  1: FSM in IDLE and FIFO empty.
- `frame_done`  out  1: one-cycle pulse at the tick that ends the last stop bit.
- `fifo_count`  out  $clog2(FIFO_DEPTH+1): current FIFO occupancy.

## Operation
- Reset values:
  - `ser_out` = 1, `din_ready` = 1, `uart_ready` = 1.
  - `tx_busy` = 0, `frame_done` = 0, `fifo_count` = 0.
  - FSM in IDLE; FIFO pointers cleared.
- FIFO:
  - Push is independent of `enable`.
  - `din_ready` = !full, computed from the registered count. When full, a push is refused even if a pop happens in the same cycle.
  - A simultaneous push and pop leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PAR, STOP. All transitions are qualified by `enable`. `ser_out` registers the bit of the state being entered.
  - IDLE, FIFO non-empty: pop into the shift register; go to START; `ser_out` ← 0.
  - IDLE, FIFO empty: stay in IDLE; `ser_out` stays 1.
  - START → DATA: `ser_out` ← sh[0]; `bit_cnt` ← 0.
  - DATA, `bit_cnt` < DATA_W-1: shift right; `ser_out` ← next bit; `bit_cnt`++.
  - DATA, `bit_cnt` = DATA_W-1, PARITY ≠ 0: go to PAR; `ser_out` ← parity bit.
  - DATA, `bit_cnt` = DATA_W-1, PARITY = 0: go to STOP; `ser_out` ← 1.
  - PAR → STOP: `ser_out` ← 1; `stop_cnt` ← 0.
  - STOP, `stop_cnt` < STOP_BITS-1: `stop_cnt`++; `ser_out` stays 1.
  - STOP, last stop bit: pulse `frame_done`. If the FIFO is non-empty, pop and go to START (`ser_out` ← 0). Otherwise go to IDLE (`ser_out` stays 1).
- Parity is computed over the DATA_W bits latched at the pop:
  - even: bit = ^data.
  - odd: bit = ~^data.
- Data words are never truncated or extended; only the DATA_W bits are sent.

## Timing
- Every line bit is held for exactly one enable period.
- Frame length = 1 + DATA_W + (PARITY≠0) + STOP_BITS ticks.
- Latency from push (FIFO empty, IDLE) to the start bit: the first `enable` cycle after the push is visible in the FIFO. That is at least one clock after the push cycle.
- Back-to-back frames have zero idle ticks between the last stop bit and the next start bit.
- `frame_done` is asserted exactly in the clock cycle of the enable that exits the final stop bit.
- `tx_busy` and `uart_ready` are combinational decodes of registered state and count.
- Reset asserted mid-frame: `ser_out` goes high immediately (asynchronous). Queued data is discarded, no partial frame resumes, and there is no `frame_done` pulse.
- `enable` held at 0 freezes the FSM and `ser_out` indefinitely; FIFO pushes still proceed.

## Structure
- Shared package `ua_pkg`:
  - FSM state encoding localparams (IDLE/START/DATA/PAR/STOP).
  - Parity mode constants PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2.
  - Shared by the future receiver.
- Sub-module `ua_tx_fifo`: synchronous FIFO with parameters `W` and `DEPTH`; provides full/empty/count and push/pop. The top level holds the FSM, shift register, `bit_cnt` and `stop_cnt`.
- Elaboration-time checks on parameter ranges; illegal values are a fatal error.

## Test plan
- 8N1, `enable` every cycle; push 0x55 → `ser_out` after the idle 1 is 0,1,0,1,0,1,0,1,0,1. `frame_done` pulses on tick 10; `uart_ready` returns to 1.
- PARITY=1, push 0x07 → parity bit 1. PARITY=2, push 0x07 → parity bit 0. Frame length is 11 ticks.
- DATA_W=7, PARITY=2, STOP_BITS=2, push 0x41 → 0,1,0,0,0,0,0,1 then parity 1, then 1,1. Frame length is 11 ticks.
- FIFO_DEPTH=4, `enable` held at 0, push 5 words back-to-back → 4 are accepted, `din_ready` = 0 on the 5th, `fifo_count` = 4. Raise `enable` → the 4 frames go out contiguously in 40 ticks; `frame_done` pulses 4 times.
- `enable` pulsing once every 16 clocks; push 0xA3 → each bit is held 16 clocks; total frame length is 160 clocks.
- Assert `rst` during DATA bit 3 with 2 words queued → `ser_out` = 1 in the same cycle and `fifo_count` = 0. After release, the line stays idle with no `frame_done`.
